// File: rtl/usb_pkg.sv
// Shared USB CRC definitions: engine state encoding, standard polynomials and
// residuals, and the single-bit remainder step used by the serial CRC engine.
package usb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } crc_state_t;

    localparam logic [4:0]  CRC5_POLY      = 5'b00101;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    // Operates on a 16-bit container; the caller keeps only its low 'width' bits.
    function automatic logic [15:0] crc_step(input logic [15:0] rem,
                                             input logic [15:0] poly,
                                             input int          width,
                                             input logic        bit_in);
        logic [3:0] msb_idx;
        logic       fb;
        msb_idx = 4'(width - 1);
        fb      = rem[msb_idx] ^ bit_in;
        return {rem[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/usb_crc_serial.sv
// Bit-serial USB CRC5/CRC16 generator and residual checker.
// Define USB_CRC_CHECK_EN to build the residual comparator behind crc_match.
module usb_crc_serial
    import usb_pkg::*;
#(
    parameter int               WIDTH    = 5,
    parameter logic [WIDTH-1:0] POLY     = CRC5_POLY,
    parameter logic [WIDTH-1:0] INIT     = '1,
    parameter logic [WIDTH-1:0] RESIDUAL = CRC5_RESIDUAL
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_en,
    input  logic s_in,
    output logic crc_out,
    output logic crc_ready,
    output logic crc_done,
    output logic crc_match
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [15:0]     POLY_EXT = 16'(POLY);

    crc_state_t       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      rem_ext, step_res;
    logic             latch_en;
    logic             unused_step;

    assign unused_step = ^step_res;

    always_comb begin
        rem_ext            = '0;
        rem_ext[WIDTH-1:0] = rem_q;
        step_res           = crc_step(rem_ext, POLY_EXT, WIDTH, s_in);

        state_d  = state_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                rem_d = INIT;
                if (start) begin
                    state_d = ACC;
                    if (bit_en) rem_d = step_res[WIDTH-1:0];
                end
            end
            ACC: begin
                if (start) begin
                    if (bit_en) rem_d = step_res[WIDTH-1:0];
                end else begin
                    state_d  = SEND;
                    cnt_d    = '0;
                    latch_en = 1'b1;
                end
            end
            SEND: begin
                // Shifting in ones leaves the remainder at INIT-like state for the next frame.
                if (bit_en) begin
                    rem_d = {rem_q[WIDTH-2:0], 1'b1};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                rem_d   = INIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign crc_ready = (state_q == SEND);
    assign crc_out   = (state_q == SEND) & ~rem_q[WIDTH-1];
    assign crc_done  = (state_q == DONE);

`ifdef USB_CRC_CHECK_EN
    logic match_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= 1'b0;
        end else if (latch_en) begin
            match_q <= (rem_q == RESIDUAL);
        end
    end

    assign crc_match = match_q & (state_q == DONE);
`else
    logic unused_chk;

    assign unused_chk = latch_en ^ (^RESIDUAL);
    assign crc_match  = 1'b0;
`endif

endmodule

// File: doc/usb_crc_serial.md
# usb_crc_serial

Parametrised bit-serial USB CRC engine: generates or checks CRC5 (token/SOF) or CRC16 (data) over a NRZ-decoded, unstuffed bit stream. It sits between the bit-unstuffer/packet encoder and the packet FSM. It accumulates the remainder while `start` is high, then shifts the complemented remainder out MSB-first. It replaces the fixed-width CRC5 block, adding width/polynomial generality, stall support and residual checking.

## Interface
- `WIDTH`, 5: CRC width; 5 or 16 supported.
- `POLY`, 5'b00101: generator polynomial without the x^WIDTH term; use 16'h8005 for CRC16.
- `INIT`, all ones: remainder preset.
- `RESIDUAL`, 5'b01100: good-packet residual; use 16'h800D for CRC16.
- Reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  high while message bits are presented; the falling edge ends the message.
- `bit_en`  in  1  qualifies `s_in` and CRC output shifting; low = stall, e.g. stuff bit.
- `s_in`  in  1  message bit, sampled when `start && bit_en`.
- `crc_out`  out  1  serial CRC bit, MSB first, complemented.
- `crc_ready`  out  1  high during SEND; `crc_out` is valid.
- `crc_done`  out  1  one-cycle pulse after the last CRC bit.
- `crc_match`  out  1  remainder == `RESIDUAL`; valid while `crc_done` is high.

## Operation
- Step function: `fb = rem[WIDTH-1] ^ s_in`; `rem <= {rem[WIDTH-2:0],0} ^ (fb ? POLY : 0)`.
- States: IDLE, ACC, SEND, DONE.
- IDLE:
  - `rem` holds `INIT`.
  - `start=1` moves to ACC.
  - If `bit_en=1` in that same cycle, the first bit is stepped from `INIT`.
- ACC:
  - Each cycle with `start && bit_en` steps `rem`.
  - `start=0` moves to SEND; `bit_cnt` is cleared.
- SEND:
  - `crc_ready=1`.
  - `crc_out = ~rem[WIDTH-1]`.
  - Each cycle with `bit_en`, `rem` shifts left by one with 1 filled in, and `bit_cnt` increments.
  - After `WIDTH` qualified shifts, moves to DONE.
  - `start` is ignored in SEND.
- DONE:
  - `crc_done=1` for one cycle.
  - `crc_match` reflects the remainder latched at the ACC→SEND transition.
  - Next state is IDLE, and `rem` reloads `INIT`.
- Checker use:
  - Feed the message plus the received CRC bits with `start` high.
  - `crc_match=1` indicates a good packet.
  - The SEND phase still runs and its output may be ignored.
- `start` high in DONE: ignored; the next message must begin from IDLE.

## Timing
- Reset values:
  - state IDLE, `rem=INIT`, `bit_cnt=0`.
  - `crc_out=0`, `crc_ready=0`, `crc_done=0`, `crc_match=0`.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- `crc_ready` rises the cycle after `start` is sampled low.
- The first CRC bit is valid in that same cycle.
- With `bit_en` held high, `crc_ready` lasts exactly `WIDTH` cycles and `crc_done` follows on the next cycle.
- A stall (`bit_en=0`) holds `crc_out`, `rem` and `bit_cnt` unchanged and extends SEND by one cycle per stall.
- `rst` in any state returns to the reset values at the next edge. A partial CRC is discarded with no `crc_done`.
- `start` pulsed for one cycle with `bit_en=0`: zero message bits; sends `~INIT` (all zeros).

## Configuration
- `USB_CRC_CHECK_EN` defined:
  - Residual comparator and the `crc_match` register are built.
  - The latched remainder is compared against `RESIDUAL`.
- Not defined:
  - `crc_match` is tied to 0 and no comparator is synthesised.
  - Generator behaviour is otherwise identical.

## Structure
- Shared package `usb_pkg`:
  - `crc_state_t` enum {IDLE, ACC, SEND, DONE}.
  - Constants `CRC5_POLY=5'b00101`, `CRC5_RESIDUAL=5'b01100`, `CRC16_POLY=16'h8005`, `CRC16_RESIDUAL=16'h800D`.
- Single module; no sub-module. The step function is a package function `crc_step`, parametrised by width through the caller.

## Test plan
- CRC5 generate, eleven 0 bits with `bit_en=1`:
  - `crc_out` sequence is 0,1,0,0,0.
  - `crc_ready` is high 5 cycles, then one `crc_done` pulse.
- CRC5 check (macro on), eleven 0 bits followed by 0,1,0,0,0 in one `start` window:
  - `crc_match=1` at `crc_done`.
  - Flipping any single bit gives `crc_match=0`.
- CRC16 (`WIDTH=16`, `POLY=16'h8005`), sixteen 1 bits: `crc_out` is sixteen 1s, then `crc_done`.
- Stall: CRC5 eleven-zero case with `bit_en` low on alternate cycles:
  - Same 01000 output sequence.
  - `crc_ready` lasts 10 cycles; each bit is held 2 cycles.
- Reset mid-SEND, `rst` asserted after the 2nd CRC bit:
  - Next cycle all outputs are 0 and there is no `crc_done`.
  - A following eleven-zero message again yields 01000.
- Macro off: the CRC5 check scenario gives `crc_match=0` throughout.
